// File: rtl/usb_rx_decoder.sv
// Low-speed USB receive decoder: SYNC hunt, NRZI decode, bit destuffing, LSB-first byte assembly, EOP/error detection.
// Outputs registered one clk after the deciding strobe, no backpressure; USB_RX_STUFF_CHECK_EN makes a stuff bit decoded as 1 an error.
module usb_rx_decoder #(
    parameter int STUFF_LEN = 6,
    parameter int EOP_MAX   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] d,
    input  logic       strobe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error
);
    localparam logic [1:0] LINE_J = 2'b01;
    localparam logic [1:0] LINE_K = 2'b10;

    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_EOP  = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    localparam int SCW = $clog2(STUFF_LEN + 1);
    localparam int ECW = $clog2(EOP_MAX + 1);

    logic [1:0]     state_q, state_d;
    logic [1:0]     prev_q, prev_d;
    logic [7:0]     hist_q, hist_d;
    logic [7:0]     byte_q, byte_d;
    logic [SCW-1:0] stuff_cnt_q, stuff_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [ECW-1:0] se0_cnt_q, se0_cnt_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           rx_active_q, rx_active_d;
    logic           rx_eop_q, rx_eop_d;
    logic           rx_error_q, rx_error_d;

    logic line_jk;
    logic bit_dec;
    logic err;

    // Anything that is neither J nor K (SE0, or the illegal SE1) is handled as SE0.
    assign line_jk = (d == LINE_J) || (d == LINE_K);
    assign bit_dec = (d == prev_q);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        hist_d      = hist_q;
        byte_d      = byte_q;
        stuff_cnt_d = stuff_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        se0_cnt_d   = se0_cnt_q;
        rx_data_d   = rx_data_q;
        rx_active_d = rx_active_q;
        rx_valid_d  = 1'b0;
        rx_eop_d    = 1'b0;
        rx_error_d  = 1'b0;
        err         = 1'b0;

        if (strobe) begin
            case (state_q)
                S_HUNT: begin
                    if (line_jk) begin
                        prev_d = d;
                        hist_d = {hist_q[6:0], bit_dec};
                        if (hist_d == 8'h01) begin
                            state_d     = S_DATA;
                            rx_active_d = 1'b1;
                            stuff_cnt_d = '0;
                            bit_cnt_d   = '0;
                        end
                    end else begin
                        prev_d = LINE_J;
                    end
                end
                S_DATA: begin
                    if (line_jk) begin
                        prev_d = d;
                        if (stuff_cnt_q == SCW'(STUFF_LEN)) begin
`ifdef USB_RX_STUFF_CHECK_EN
                            if (bit_dec) begin
                                err = 1'b1;
                            end else begin
                                stuff_cnt_d = '0;
                            end
`else
                            stuff_cnt_d = '0;
`endif
                        end else begin
                            stuff_cnt_d = bit_dec ? stuff_cnt_q + SCW'(1) : '0;
                            byte_d      = {bit_dec, byte_q[7:1]};
                            bit_cnt_d   = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_d  = byte_d;
                                rx_valid_d = 1'b1;
                            end
                        end
                    end else begin
                        state_d   = S_EOP;
                        se0_cnt_d = ECW'(1);
                    end
                end
                S_EOP: begin
                    if (d == LINE_J) begin
                        state_d     = S_HUNT;
                        prev_d      = LINE_J;
                        rx_active_d = 1'b0;
                        if (bit_cnt_q == 3'd0) begin
                            rx_eop_d = 1'b1;
                        end else begin
                            rx_error_d = 1'b1;
                        end
                    end else if (d == LINE_K) begin
                        err = 1'b1;
                    end else if (se0_cnt_q == ECW'(EOP_MAX)) begin
                        err = 1'b1;
                    end else begin
                        se0_cnt_d = se0_cnt_q + ECW'(1);
                    end
                end
                default: begin
                    if (d == LINE_J) begin
                        state_d = S_HUNT;
                        prev_d  = LINE_J;
                        hist_d  = '0;
                    end
                end
            endcase

            if (err) begin
                state_d     = S_WAIT;
                rx_active_d = 1'b0;
                rx_error_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HUNT;
            prev_q      <= LINE_J;
            hist_q      <= '0;
            byte_q      <= '0;
            stuff_cnt_q <= '0;
            bit_cnt_q   <= '0;
            se0_cnt_q   <= '0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            hist_q      <= hist_d;
            byte_q      <= byte_d;
            stuff_cnt_q <= stuff_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            se0_cnt_q   <= se0_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_eop_q    <= rx_eop_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_active = rx_active_q;
    assign rx_eop    = rx_eop_q;
    assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Bench for usb_rx_decoder: NRZI/stuffing line encoder drives directed packets, a queue holds expected pulses.
// Event encoding in the queue: {valid, eop, error, data}; data is zero for eop/error events.
module tb_usb_rx_decoder;
    localparam logic [1:0] LJ   = 2'b01;
    localparam logic [1:0] LK   = 2'b10;
    localparam logic [1:0] LSE0 = 2'b00;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] d      = LJ;
    logic       strobe = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_error;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];
    logic [1:0]  tx_prev = LJ;
    int          ones = 0;

    usb_rx_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .strobe    (strobe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_active (rx_active),
        .rx_eop    (rx_eop),
        .rx_error  (rx_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [10:0] obs;
        logic [10:0] want;
        if (rx_valid || rx_eop || rx_error) begin
            obs  = {rx_valid, rx_eop, rx_error, (rx_valid ? rx_data : 8'h00)};
            want = 11'h000;
            if (exp_q.size() > 0) want = exp_q.pop_front();
            chk("event", 32'(obs), 32'(want));
        end
    end

    function automatic logic [10:0] ev_valid(input logic [7:0] v);
        return {3'b100, v};
    endfunction
    localparam logic [10:0] EV_EOP = {3'b010, 8'h00};
    localparam logic [10:0] EV_ERR = {3'b001, 8'h00};

    task automatic send_line(input logic [1:0] ls);
        repeat (3) @(posedge clk);
        #1;
        d      = ls;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        if (ls != LSE0) tx_prev = ls;
    endtask

    task automatic raw_bit(input logic b);
        send_line(b ? tx_prev : ((tx_prev == LJ) ? LK : LJ));
    endtask

    task automatic data_bit(input logic b);
        raw_bit(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            raw_bit(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) raw_bit(1'b0);
        raw_bit(1'b1);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        exp_q.push_back(ev_valid(v));
        for (int i = 0; i < 8; i++) data_bit(v[i]);
    endtask

    task automatic send_eop();
        send_line(LSE0);
        send_line(LSE0);
        send_line(LJ);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_data", 32'(rx_data), 32'h00);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_active", 32'(rx_active), 32'h0);
        chk("reset_eop", 32'(rx_eop), 32'h0);
        chk("reset_error", 32'(rx_error), 32'h0);

        // Basic packet
        send_sync();
        chk("active_after_sync", 32'(rx_active), 32'h1);
        send_byte(8'hA5);
        exp_q.push_back(EV_EOP);
        send_eop();
        chk("active_after_eop", 32'(rx_active), 32'h0);
        chk("data_hold_a5", 32'(rx_data), 32'hA5);

        // Stuffing across bytes, and 8th bit coinciding with the 6th one
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'hFC);
        send_byte(8'h00);
        exp_q.push_back(EV_EOP);
        send_eop();
        chk("active_after_stuff_pkt", 32'(rx_active), 32'h0);

        // Seven decoded ones: stuff bit received as 1
        send_sync();
`ifdef USB_RX_STUFF_CHECK_EN
        exp_q.push_back(EV_ERR);
        for (int i = 0; i < 7; i++) raw_bit(1'b1);
        chk("active_after_stuff_err", 32'(rx_active), 32'h0);
        send_line(LJ);
`else
        exp_q.push_back(ev_valid(8'h3F));
        for (int i = 0; i < 7; i++) raw_bit(1'b1);
        raw_bit(1'b0);
        raw_bit(1'b0);
        chk("active_mid_stuff1", 32'(rx_active), 32'h1);
        exp_q.push_back(EV_EOP);
        send_eop();
`endif

        // Misaligned EOP after 5 bits
        send_sync();
        data_bit(1'b1);
        data_bit(1'b0);
        data_bit(1'b1);
        data_bit(1'b1);
        data_bit(1'b0);
        exp_q.push_back(EV_ERR);
        send_eop();
        chk("active_after_misaligned", 32'(rx_active), 32'h0);

        // Overlong EOP, then recovery
        send_sync();
        chk("active_after_resync", 32'(rx_active), 32'h1);
        send_byte(8'h5A);
        send_line(LSE0);
        send_line(LSE0);
        send_line(LSE0);
        chk("active_during_eop", 32'(rx_active), 32'h1);
        exp_q.push_back(EV_ERR);
        send_line(LSE0);
        chk("active_after_long_eop", 32'(rx_active), 32'h0);
        send_line(LJ);
        send_sync();
        send_byte(8'hC3);
        exp_q.push_back(EV_EOP);
        send_eop();

        // Reset in the middle of a byte
        send_sync();
        data_bit(1'b0);
        data_bit(1'b1);
        data_bit(1'b1);
        data_bit(1'b0);
        chk("data_before_reset", 32'(rx_data), 32'hC3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_data", 32'(rx_data), 32'h00);
        chk("rst_mid_active", 32'(rx_active), 32'h0);
        chk("rst_mid_valid", 32'(rx_valid), 32'h0);
        chk("rst_mid_eop", 32'(rx_eop), 32'h0);
        chk("rst_mid_error", 32'(rx_error), 32'h0);
        tx_prev = LJ;
        send_sync();
        send_byte(8'h3C);
        exp_q.push_back(EV_EOP);
        send_eop();
        chk("active_after_3c", 32'(rx_active), 32'h0);

        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
